// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, the controller
// state encoding, the default data-memory size and the access legality check.
package lsu_pkg;

    localparam int unsigned LSU_MEM_BYTES = 4096;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_e;

    // An access is refused when it lies beyond the memory, is not naturally
    // aligned for its size, or uses the reserved size code.
    function automatic logic access_error(input logic [31:0] addr,
                                          input logic [1:0]  size,
                                          input logic [31:0] limit);
        logic bad;
        bad = (addr >= limit);
        if (size == SZ_HALF) begin
            bad = bad | addr[0];
        end else if (size == SZ_WORD) begin
            bad = bad | (addr[1:0] != 2'b00);
        end else if (size == SZ_ILL) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: extracts and extends a loaded byte/halfword and
// merges sub-word store data into the word read back from memory.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel    = word_i[7:0];
        half_sel    = word_i[15:0];
        load_data_o = word_i;
        merged_o    = word_i;

        case (offset_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

        if (size_i == SZ_BYTE) begin
            load_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            case (offset_i)
                2'd0:    merged_o[7:0]   = wdata_i[7:0];
                2'd1:    merged_o[15:8]  = wdata_i[7:0];
                2'd2:    merged_o[23:16] = wdata_i[7:0];
                default: merged_o[31:24] = wdata_i[7:0];
            endcase
        end else if (size_i == SZ_HALF) begin
            load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            if (offset_i[1]) begin
                merged_o[31:16] = wdata_i;
            end else begin
                merged_o[15:0] = wdata_i;
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller for the single-port word-addressed data
// memory: sub-word loads with extension, read-modify-write sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = LSU_MEM_BYTES,
    parameter int          DATA_W    = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              IsStore,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [DATA_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [DATA_W-1:0] LoadData,
    output logic [DATA_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] MemReadData
);

    // Handshake: Req is only looked at in IDLE, after which the CPU holds its
    // inputs until the single-cycle Done; Busy covers every non-IDLE cycle.
    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        store_q, store_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [31:0] align_load;
    logic [31:0] align_merged;

    lsu_lane_align u_align (
        .word_i      (MemReadData),
        .offset_i    (addr_q[1:0]),
        .size_i      (size_q),
        .unsigned_i  (uns_q),
        .wdata_i     (wdata_q),
        .load_data_o (align_load),
        .merged_o    (align_merged)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        store_d     = store_q;
        uns_d       = uns_q;
        err_d       = err_q;
        load_data_d = load_data_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (Req) begin
                    addr_d  = Address;
                    wdata_d = WriteData[15:0];
                    size_d  = Size;
                    store_d = IsStore;
                    uns_d   = Unsigned;
                    err_d   = access_error(Address, Size, 32'(MEM_BYTES));
                    if (err_d) begin
                        state_d = ST_RESP;
                    end else if (IsStore && Size == SZ_WORD) begin
                        mem_wdata_d = WriteData;
                        state_d     = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
                if (store_q) begin
                    mem_wdata_d = align_merged;
                    state_d     = ST_WRITE;
                end else begin
                    load_data_d = align_load;
                    state_d     = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            store_q     <= 1'b0;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            store_q     <= store_d;
            uns_q       <= uns_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Every output is a register or a pure decode of state_q.
    assign Busy         = (state_q != ST_IDLE);
    assign Done         = (state_q == ST_RESP);
    assign Error        = err_q;
    assign MemRead      = (state_q == ST_READ);
    assign MemWrite     = (state_q == ST_WRITE);
    assign LoadData     = load_data_q;
    assign MemAddress   = {addr_q[31:2], 2'b00};
    assign MemWriteData = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural model of the team's
// single-port data memory (registered read, write has priority).
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req;
    logic        IsStore;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [31:0] LoadData;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemReadData;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    load_store_unit #(.MEM_BYTES(4096)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Req          (Req),
        .IsStore      (IsStore),
        .Size         (Size),
        .Unsigned     (Unsigned),
        .Address      (Address),
        .WriteData    (WriteData),
        .Busy         (Busy),
        .Done         (Done),
        .Error        (Error),
        .LoadData     (LoadData),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemReadData  (MemReadData)
    );

    logic [31:0] mem [0:1023];

    always @(posedge Clk) begin
        if (MemWrite) begin
            mem[MemAddress[11:2]] <= MemWriteData;
        end else if (MemRead) begin
            MemReadData <= mem[MemAddress[11:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one request from an IDLE cycle, waits (bounded) for Done, then
    // lets the RESP cycle finish so the unit is IDLE again on return.
    task automatic run_op(input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output int n_rd, output int n_wr, output int n_both,
                          output logic [31:0] wr_data, output logic [31:0] rd_addr,
                          output logic err, output logic [31:0] ld);
        lat = 0; n_rd = 0; n_wr = 0; n_both = 0;
        wr_data = '0; rd_addr = '0; err = 1'b0; ld = '0;
        Req = 1'b1; IsStore = st; Size = sz; Unsigned = un; Address = a; WriteData = wd;
        do begin
            @(posedge Clk); #1;
            lat++;
            if (MemRead) begin n_rd++; rd_addr = MemAddress; end
            if (MemWrite) begin n_wr++; wr_data = MemWriteData; end
            if (MemRead && MemWrite) n_both++;
        end while (!Done && lat < 20);
        err = Error;
        ld  = LoadData;
        Req = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] exp_ld);
        int lat, n_rd, n_wr, n_both;
        logic [31:0] wr_data, rd_addr, ld;
        logic err;
        run_op(1'b0, sz, un, a, 32'h0, lat, n_rd, n_wr, n_both, wr_data, rd_addr, err, ld);
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_nrd"}, 32'(n_rd), 32'd1);
        check({tag, "_nwr"}, 32'(n_wr), 32'd0);
        check({tag, "_addr"}, rd_addr, {a[31:2], 2'b00});
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_data"}, ld, exp_ld);
    endtask

    task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_word);
        int lat, n_rd, n_wr, n_both;
        logic [31:0] wr_data, rd_addr, ld;
        logic err;
        run_op(1'b1, sz, 1'b0, a, wd, lat, n_rd, n_wr, n_both, wr_data, rd_addr, err, ld);
        check({tag, "_lat"}, 32'(lat), (sz == 2'b10) ? 32'd2 : 32'd4);
        check({tag, "_nrd"}, 32'(n_rd), (sz == 2'b10) ? 32'd0 : 32'd1);
        check({tag, "_nwr"}, 32'(n_wr), 32'd1);
        check({tag, "_both"}, 32'(n_both), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_wdata"}, wr_data, exp_word);
        check({tag, "_mem"}, mem[a[11:2]], exp_word);
    endtask

    task automatic do_err(input string tag, input logic st, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] exp_ld);
        int lat, n_rd, n_wr, n_both;
        logic [31:0] wr_data, rd_addr, ld;
        logic err;
        run_op(st, sz, 1'b0, a, 32'h5A5A5A5A, lat, n_rd, n_wr, n_both, wr_data, rd_addr, err, ld);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_nrd"}, 32'(n_rd), 32'd0);
        check({tag, "_nwr"}, 32'(n_wr), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd1);
        check({tag, "_ld"}, ld, exp_ld);
        check({tag, "_err_clr"}, 32'(Error), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_done"}, 32'(Done), 32'd0);
        check({tag, "_error"}, 32'(Error), 32'd0);
        check({tag, "_mrd"}, 32'(MemRead), 32'd0);
        check({tag, "_mwr"}, 32'(MemWrite), 32'd0);
        check({tag, "_ld"}, LoadData, 32'h0);
        check({tag, "_maddr"}, MemAddress, 32'h0);
        check({tag, "_mwdata"}, MemWriteData, 32'h0);
    endtask

    initial begin
        int guard;
        Reset = 1'b1; Req = 1'b0; IsStore = 1'b0; Size = 2'b00; Unsigned = 1'b0;
        Address = '0; WriteData = '0;
        repeat (2) @(posedge Clk);
        #1;
        check_all_zero("reset");
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Word store then word load
        do_store("sw10", 2'b10, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF);
        do_load("lw10", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);

        // Byte / halfword loads with both extensions
        do_store("sw20", 2'b10, 32'h20, 32'h80FF7F01, 32'h80FF7F01);
        do_load("lb23", 2'b00, 1'b0, 32'h23, 32'hFFFFFF80);
        do_load("lbu23", 2'b00, 1'b1, 32'h23, 32'h00000080);
        do_load("lb21", 2'b00, 1'b0, 32'h21, 32'h0000007F);
        do_load("lhu22", 2'b01, 1'b1, 32'h22, 32'h000080FF);
        do_load("lwu20", 2'b10, 1'b1, 32'h20, 32'h80FF7F01);
        do_load("lh22", 2'b01, 1'b0, 32'h22, 32'hFFFF80FF);

        // Errors: LoadData keeps the last load result
        do_err("lh41", 1'b0, 2'b01, 32'h41, 32'hFFFF80FF);
        do_err("lw42", 1'b0, 2'b10, 32'h42, 32'hFFFF80FF);
        do_err("sz11", 1'b0, 2'b11, 32'h40, 32'hFFFF80FF);
        do_err("lw1000", 1'b0, 2'b10, 32'h1000, 32'hFFFF80FF);
        do_err("sh43", 1'b1, 2'b01, 32'h43, 32'hFFFF80FF);

        // Sub-word stores; upper WriteData bits must not leak into memory
        do_store("sw30", 2'b10, 32'h30, 32'h11223344, 32'h11223344);
        do_store("sb31", 2'b00, 32'h31, 32'h123456AB, 32'h1122AB44);
        do_store("sh32", 2'b01, 32'h32, 32'hFFFFCAFE, 32'hCAFEAB44);
        do_load("lw30", 2'b10, 1'b0, 32'h30, 32'hCAFEAB44);

        // Req while busy is ignored; Req held over Done is taken after RESP
        Req = 1'b1; IsStore = 1'b0; Size = 2'b10; Unsigned = 1'b0; Address = 32'h10;
        @(posedge Clk); #1;
        check("busy_rd", 32'(MemRead), 32'd1);
        check("busy_addr", MemAddress, 32'h10);
        Address = 32'h20; Size = 2'b00; Unsigned = 1'b1;
        guard = 0;
        while (!Done && guard < 20) begin
            @(posedge Clk); #1;
            guard++;
            if (MemRead) check("busy_ign_addr", MemAddress, 32'h10);
        end
        check("busy_done", 32'(Done), 32'd1);
        check("busy_ld", LoadData, 32'hDEADBEEF);
        @(posedge Clk); #1;
        check("held_idle", 32'(Busy), 32'd0);
        @(posedge Clk); #1;
        check("held_acc_rd", 32'(MemRead), 32'd1);
        check("held_acc_addr", MemAddress, 32'h20);
        Req = 1'b0;
        guard = 0;
        while (!Done && guard < 20) begin
            @(posedge Clk); #1;
            guard++;
        end
        check("held_done", 32'(Done), 32'd1);
        check("held_ld", LoadData, 32'h00000001);
        @(posedge Clk); #1;

        // Reset during WAIT of a byte store: nothing written, no Done
        do_store("sw34", 2'b10, 32'h34, 32'h55667788, 32'h55667788);
        Req = 1'b1; IsStore = 1'b1; Size = 2'b00; Address = 32'h34; WriteData = 32'h99;
        @(posedge Clk); #1;
        check("rstw_read", 32'(MemRead), 32'd1);
        @(posedge Clk); #1;
        check("rstw_wait", 32'(Busy & ~MemRead & ~MemWrite), 32'd1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0; Req = 1'b0;
        check("rstw_busy", 32'(Busy), 32'd0);
        check("rstw_done", 32'(Done), 32'd0);
        check("rstw_mwr", 32'(MemWrite), 32'd0);
        @(posedge Clk); #1;
        check("rstw_mwr2", 32'(MemWrite), 32'd0);
        check("rstw_done2", 32'(Done), 32'd0);
        check("rstw_mem", mem[10'd13], 32'h55667788);

        // Reset in the WRITE cycle: the sampled write still lands
        Req = 1'b1; IsStore = 1'b1; Size = 2'b00; Address = 32'h34; WriteData = 32'h99;
        repeat (3) @(posedge Clk);
        #1;
        check("rstwr_mwr", 32'(MemWrite), 32'd1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0; Req = 1'b0;
        check("rstwr_mem", mem[10'd13], 32'h55667799);
        check_all_zero("rstwr");
        @(posedge Clk); #1;
        do_load("lw34", 2'b10, 1'b0, 32'h34, 32'h55667799);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
